// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared types and helpers for the serial link transceiver
package serial_link_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_PEER, SHIFT, PARITY, GAP} tx_state_t;
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/serial_link_xcvr_fifo.sv
// sync_fifo: first-word-fall-through circular buffer for received words
module sync_fifo import serial_link_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [cnt_w(DEPTH)-1:0]    o_count,
  output logic [WIDTH-1:0]           o_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign o_empty = o_count == '0;
  assign o_full  = o_count == CW'(DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  // a pop frees the slot a same-cycle push needs, so full+pop still accepts
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      o_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      o_count <= o_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/serial_link_xcvr.sv
// serial_link_xcvr: three-wire framed serial transmitter and FIFO-backed receiver
module serial_link_xcvr import serial_link_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CLK_DIV   = 4,
  parameter int PARITY_EN = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [WIDTH-1:0]        rx_data,
  output logic                    rx_valid,
  input  logic                    rx_pop,
  output logic [cnt_w(DEPTH)-1:0] rx_count,
  output logic                    local_ready_out,
  input  logic                    peer_ready_in,
  output logic                    ser_clk_out,
  output logic                    ser_data_out,
  output logic                    ser_frame_out,
  input  logic                    ser_clk_in,
  input  logic                    ser_data_in,
  input  logic                    ser_frame_in,
  output logic                    parity_err,
  output logic                    overflow
);
  localparam int NB = WIDTH + PARITY_EN;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WIDTH);
  localparam int RW = $clog2(NB + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [RW-1:0] RX_FULL  = RW'(NB);
  logic [1:0] r_pr_sync, r_ck_sync, r_dt_sync, r_fr_sync;
  logic r_ck_q, r_fr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pr_sync <= '0;
      r_ck_sync <= '0;
      r_dt_sync <= '0;
      r_fr_sync <= '0;
      r_ck_q    <= 1'b0;
      r_fr_q    <= 1'b0;
    end else begin
      r_pr_sync <= {r_pr_sync[0], peer_ready_in};
      r_ck_sync <= {r_ck_sync[0], ser_clk_in};
      r_dt_sync <= {r_dt_sync[0], ser_data_in};
      r_fr_sync <= {r_fr_sync[0], ser_frame_in};
      r_ck_q    <= r_ck_sync[1];
      r_fr_q    <= r_fr_sync[1];
    end
  tx_state_t r_state, w_state;
  logic [WIDTH-1:0] r_shift, w_shift;
  logic [DW-1:0] r_div, w_div;
  logic [BW-1:0] r_bit, w_bit;
  logic r_par, w_par, w_bit_end, w_frame;
  assign w_bit_end = r_div == DIV_LAST;
  assign w_frame   = w_state == SHIFT || w_state == PARITY;
  assign tx_ready  = r_state == IDLE;
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_par   = r_par;
    w_div   = '0;
    w_bit   = r_bit;
    unique case (r_state)
      IDLE: if (tx_valid) begin
        w_state = WAIT_PEER;
        w_shift = tx_data;
        w_par   = even_parity(32'(tx_data));
      end
      WAIT_PEER: begin
        w_bit = '0;
        if (r_pr_sync[1]) w_state = SHIFT;
      end
      SHIFT: begin
        w_div = w_bit_end ? '0 : r_div + DW'(1);
        if (w_bit_end) begin
          w_shift = r_shift << 1;
          w_bit   = r_bit + BW'(1);
          if (r_bit == BIT_LAST) w_state = PARITY_EN != 0 ? PARITY : GAP;
        end
      end
      default: begin
        w_div = w_bit_end ? '0 : r_div + DW'(1);
        if (w_bit_end) w_state = r_state == PARITY ? GAP : IDLE;
      end
    endcase
  end
  // serial outputs are registered from next-state values so they never glitch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_div         <= '0;
      r_bit         <= '0;
      ser_frame_out <= 1'b0;
      ser_clk_out   <= 1'b0;
      ser_data_out  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_shift       <= w_shift;
      r_par         <= w_par;
      r_div         <= w_div;
      r_bit         <= w_bit;
      ser_frame_out <= w_frame;
      ser_clk_out   <= w_frame && w_div >= DIV_HALF;
      ser_data_out  <= w_state == PARITY ? w_par : w_state == SHIFT && w_shift[WIDTH-1];
    end
  logic [NB-1:0] r_rx_sh;
  logic [RW-1:0] r_rx_cnt;
  logic w_rise, w_fall, w_done, w_bad, w_full, w_empty;
  assign w_rise   = r_ck_sync[1] & ~r_ck_q & r_fr_sync[1];
  assign w_fall   = ~r_fr_sync[1] & r_fr_q;
  assign w_done   = r_rx_cnt == RX_FULL;
  assign w_bad    = PARITY_EN != 0 && ^r_rx_sh;
  assign rx_valid = ~w_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rx_sh         <= '0;
      r_rx_cnt        <= '0;
      parity_err      <= 1'b0;
      overflow        <= 1'b0;
      local_ready_out <= 1'b1;
    end else begin
      if (w_done || w_fall) r_rx_cnt <= '0;
      else if (w_rise) begin
        r_rx_cnt <= r_rx_cnt + RW'(1);
        r_rx_sh  <= {r_rx_sh[NB-2:0], r_dt_sync[1]};
      end
      parity_err      <= w_done & w_bad;
      overflow        <= w_done & ~w_bad & w_full & ~rx_pop;
      local_ready_out <= ~w_full;
    end
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_done & ~w_bad),
    .i_pop   (rx_pop),
    .i_data  (r_rx_sh[NB-1 -: WIDTH]),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (rx_count),
    .o_data  (rx_data)
  );
endmodule

// File: tb/tb_serial_link_xcvr.sv
// tb_serial_link_xcvr: loopback/direct-drive bench with a timeline model of the link
module tb_serial_link_xcvr;
  localparam int W = 8, D = 4, CD = 4, NB = W, TL = (NB + 1) * CD;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] a_tx_data = '0;
  logic a_tx_valid = 0, a_rx_pop = 0, a_peer = 1, lb = 1, to_b = 0;
  logic d_clk = 0, d_data = 0, d_frame = 0;
  logic a_tx_ready, a_rx_valid, a_lr, a_sck, a_sdt, a_sfr, a_perr, a_ovf;
  logic [W-1:0] a_rx_data;
  logic [2:0] a_rx_count;
  logic a_ck_in, a_dt_in, a_fr_in;
  logic b_tx_ready, b_rx_valid, b_lr, b_sck, b_sdt, b_sfr, b_perr, b_ovf;
  logic [W-1:0] b_rx_data;
  logic [2:0] b_rx_count;
  assign a_ck_in = lb ? a_sck : d_clk & ~to_b;
  assign a_dt_in = lb ? a_sdt : d_data & ~to_b;
  assign a_fr_in = lb ? a_sfr : d_frame & ~to_b;
  serial_link_xcvr #(.WIDTH(W), .DEPTH(D), .CLK_DIV(CD), .PARITY_EN(0)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_pop(a_rx_pop), .rx_count(a_rx_count),
    .local_ready_out(a_lr), .peer_ready_in(a_peer), .ser_clk_out(a_sck), .ser_data_out(a_sdt),
    .ser_frame_out(a_sfr), .ser_clk_in(a_ck_in), .ser_data_in(a_dt_in), .ser_frame_in(a_fr_in),
    .parity_err(a_perr), .overflow(a_ovf));
  serial_link_xcvr #(.WIDTH(W), .DEPTH(D), .CLK_DIV(CD), .PARITY_EN(1)) u_b (
    .clk(clk), .rst(rst), .tx_data('0), .tx_valid(1'b0), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_pop(1'b0), .rx_count(b_rx_count),
    .local_ready_out(b_lr), .peer_ready_in(1'b1), .ser_clk_out(b_sck), .ser_data_out(b_sdt),
    .ser_frame_out(b_sfr), .ser_clk_in(d_clk & to_b), .ser_data_in(d_data & to_b),
    .ser_frame_in(d_frame & to_b), .parity_err(b_perr), .overflow(b_ovf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: TX as a timeline of cycles since frame start, RX as bit collection on
  // the raw wire samples with a fixed sync/detect/push delay, FIFO as a queue.
  typedef struct packed { int due; logic [W-1:0] w; } ev_t;
  ev_t pend[$];
  logic [W-1:0] mq[$];
  int cyc = 0, mt_state = 0, mt_t = 0, mr_cnt = 0;
  logic [W-1:0] mt_word = '0, mr_sh = '0;
  logic p1 = 0, p2 = 0, x_ck = 0, x_fr = 0;
  logic e_frame = 0, e_clk = 0, e_data = 0, m_lr = 1, m_ovf = 0;
  initial forever begin : model
    logic s_ck, s_dt, s_fr, popped, was_full;
    @(posedge clk or posedge rst);
    if (rst) begin
      pend.delete(); mq.delete();
      cyc = 0; mt_state = 0; mt_t = 0; mr_cnt = 0;
      p1 = 0; p2 = 0; x_ck = 0; x_fr = 0;
      e_frame = 0; e_clk = 0; e_data = 0; m_lr = 1; m_ovf = 0;
    end else begin
      cyc++;
      s_ck = lb ? e_clk : d_clk & ~to_b;
      s_dt = lb ? e_data : d_data & ~to_b;
      s_fr = lb ? e_frame : d_frame & ~to_b;
      if (s_ck && !x_ck && s_fr) begin
        mr_sh = {mr_sh[W-2:0], s_dt};
        mr_cnt++;
        if (mr_cnt == NB) begin pend.push_back('{cyc + 3, mr_sh}); mr_cnt = 0; end
      end else if (x_fr && !s_fr) mr_cnt = 0;
      x_ck = s_ck; x_fr = s_fr;
      popped = a_rx_pop && mq.size() > 0;
      was_full = mq.size() == D;
      m_lr = mq.size() < D;
      if (popped) void'(mq.pop_front());
      m_ovf = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (was_full && !popped) m_ovf = 1; else mq.push_back(pend[0].w);
        void'(pend.pop_front());
      end
      if (mt_state == 0) begin
        if (a_tx_valid) begin mt_state = 1; mt_word = a_tx_data; end
      end else if (mt_state == 1) begin
        if (p2) begin mt_state = 2; mt_t = 0; end
      end else begin
        mt_t++;
        if (mt_t == TL) mt_state = 0;
      end
      p2 = p1; p1 = a_peer;
      e_frame = mt_state == 2 && mt_t < NB * CD;
      e_clk = e_frame && (mt_t % CD) >= CD / 2;
      e_data = e_frame ? mt_word[W - 1 - mt_t / CD] : 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("tx_ready", a_tx_ready, mt_state == 0);
    chk("ser_frame_out", a_sfr, e_frame);
    chk("ser_clk_out", a_sck, e_clk);
    chk("ser_data_out", a_sdt, e_data);
    chk("rx_valid", a_rx_valid, mq.size() > 0);
    chk("rx_count", a_rx_count, mq.size());
    chk("rx_data", a_rx_data, mq.size() > 0 ? mq[0] : '0);
    chk("local_ready_out", a_lr, m_lr);
    chk("overflow", a_ovf, m_ovf);
    chk("parity_err", a_perr, 0);
  end

  int frame_len = 0, a_ovf_n = 0, a_perr_n = 0, b_perr_n = 0, b_ovf_n = 0;
  logic [W-1:0] cap = '0;
  logic last_sck = 0;
  initial forever begin
    @(posedge clk); #1;
    if (a_sfr) frame_len++;
    if (a_sck && !last_sck) cap = {cap[W-2:0], a_sdt};
    last_sck = a_sck;
    a_ovf_n += int'(a_ovf); a_perr_n += int'(a_perr);
    b_perr_n += int'(b_perr); b_ovf_n += int'(b_ovf);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_tx(input logic [W-1:0] w);
    int k = 0;
    while (!a_tx_ready && k < 500) begin @(negedge clk); k++; end
    if (k == 500) chk("tx_ready_timeout", 0, 1);
    a_tx_data = w; a_tx_valid = 1;
    @(negedge clk);
    a_tx_valid = 0;
  endtask
  task automatic wait_cnt(input int n);
    int k = 0;
    while (a_rx_count != 3'(n) && k < 400) begin @(negedge clk); k++; end
    chk("wait_rx_count", a_rx_count, n);
  endtask
  task automatic pop_chk(input logic [W-1:0] w);
    chk("pop_data", a_rx_data, w);
    a_rx_pop = 1; @(negedge clk); a_rx_pop = 0;
  endtask
  task automatic rx_send(input logic [8:0] bits, input int nb, input int n);
    d_frame = 1;
    for (int i = nb - 1; i >= nb - n; i--) begin
      d_data = bits[i]; d_clk = 0; tick(CD / 2);
      d_clk = 1; tick(CD / 2);
    end
    d_clk = 0; d_frame = 0; d_data = 0;
    tick(2 * CD);
  endtask

  initial begin
    tick(2);
    chk("rst_tx_ready", a_tx_ready, 1);
    chk("rst_local_ready", a_lr, 1);
    chk("rst_rx_count", a_rx_count, 0);
    rst = 0;
    tick(3);
    frame_len = 0;
    send_tx(8'hA5);
    wait_cnt(1);
    chk("a5_frame_len", frame_len, 32);
    chk("a5_bits", cap, 8'hA5);
    chk("a5_rx_data", a_rx_data, 8'hA5);
    chk("a5_flags", a_ovf_n + a_perr_n, 0);
    pop_chk(8'hA5);
    a_peer = 0;
    send_tx(8'h3C);
    tick(5);
    chk("wait_tx_ready", a_tx_ready, 0);
    chk("wait_frame", a_sfr, 0);
    a_peer = 1;
    tick(2);
    chk("peer_frame_2", a_sfr, 0);
    tick(1);
    chk("peer_frame_3", a_sfr, 1);
    wait_cnt(1);
    pop_chk(8'h3C);
    tick(TL);
    lb = 0;
    rx_send(9'h0FF, 8, 5);
    chk("partial_count", a_rx_count, 0);
    rx_send(9'h081, 8, 8);
    wait_cnt(1);
    chk("partial_flags", a_ovf_n + a_perr_n, 0);
    pop_chk(8'h81);
    to_b = 1;
    rx_send(9'h01F, 9, 9);
    tick(4);
    chk("b_parity_err", b_perr_n, 1);
    chk("b_bad_count", b_rx_count, 0);
    rx_send(9'h01E, 9, 9);
    tick(4);
    chk("b_good_count", b_rx_count, 1);
    chk("b_good_data", b_rx_data, 8'h0F);
    chk("b_perr_total", b_perr_n, 1);
    chk("b_no_ovf", b_ovf_n, 0);
    chk("b_tx_idle", {b_tx_ready, b_sfr, b_sck, b_sdt, b_lr}, 5'b10001);
    to_b = 0; lb = 1;
    for (int i = 1; i <= 5; i++) send_tx(8'(i));
    tick(TL + 10);
    chk("ovf_count", a_rx_count, 4);
    chk("ovf_pulses", a_ovf_n, 1);
    chk("ovf_local_ready", a_lr, 0);
    for (int i = 1; i <= 4; i++) pop_chk(8'(i));
    send_tx(8'h77);
    wait_cnt(1);
    send_tx(8'hFF);
    tick(10);
    #2 rst = 1;
    #1;
    chk("mid_rst_tx_ready", a_tx_ready, 1);
    chk("mid_rst_ser", {a_sck, a_sdt, a_sfr}, 0);
    chk("mid_rst_rx", {a_rx_valid, a_rx_count, a_rx_data}, 0);
    chk("mid_rst_flags", {a_lr, a_ovf, a_perr}, 3'b100);
    tick(2);
    rst = 0;
    tick(2);
    send_tx(8'h12);
    wait_cnt(1);
    chk("post_rst_data", a_rx_data, 8'h12);
    pop_chk(8'h12);
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_link_xcvr.md
Name: serial_link_xcvr

Overview:
- Parametrised successor to the station-to-station serial transfer path.
- Serialises WIDTH-bit words onto a three-wire link: clock, data and frame (ready-to-transmit). Transmission waits on the peer's ready-for-transfer.
- Receives the same framing from a peer into a DEPTH-entry FIFO, with optional even parity and overflow/parity error flags.
- Sits between the station logic (scanner/transfer-centre) and the GPIO pins, in the divided-clock domain.

Parameters:
- WIDTH, 8: payload bits per word, 2..32.
- DEPTH, 4: RX FIFO entries; power of 2, at least 2.
- CLK_DIV, 4: clk cycles per serial bit; even, at least 2.
- PARITY_EN, 0: 1 appends and checks one even-parity bit after the payload.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  WIDTH  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter idle; the word is accepted when tx_valid is also high.
- rx_data  out  WIDTH  FIFO head (first-word-fall-through).
- rx_valid  out  1  FIFO not empty.
- rx_pop  in  1  consume the head; ignored when rx_valid=0.
- rx_count  out  clog2(DEPTH)+1  FIFO occupancy.
- local_ready_out  out  1  registered; 1 when rx_count<DEPTH. Drives the peer's peer_ready_in.
- peer_ready_in  in  1  async; the peer can accept a word.
- ser_clk_out  out  1  serial clock to peer.
- ser_data_out  out  1  serial data to peer.
- ser_frame_out  out  1  high for the duration of a word.
- ser_clk_in  in  1  async serial clock from peer.
- ser_data_in  in  1  async serial data from peer.
- ser_frame_in  in  1  async frame from peer.
- parity_err  out  1  one-cycle pulse when a word is dropped for bad parity.
- overflow  out  1  one-cycle pulse when a word is dropped because the FIFO is full.

Behaviour:
- Reset (async, any time):
  - TX FSM goes to IDLE; tx_ready=1 after reset.
  - ser_clk_out, ser_data_out, ser_frame_out = 0.
  - FIFO is emptied: rx_valid=0, rx_count=0, rx_data=0.
  - local_ready_out=1; parity_err=0, overflow=0.
  - RX shift register and bit counter are cleared.
  - A frame in flight is aborted; the peer discards its partial word.
- Input synchronisation: all async inputs (peer_ready_in, ser_*_in) pass through 2-flop synchronisers before use.
- TX FSM states:
  - IDLE: tx_ready=1. tx_valid=1 latches tx_data into the shift register (and computes parity) -> WAIT_PEER.
  - WAIT_PEER: hold until synced peer_ready=1 -> SHIFT; ser_frame_out rises on entry.
  - SHIFT: each bit lasts CLK_DIV cycles, sent MSB first.
    - ser_data_out changes only at bit start.
    - ser_clk_out is 0 for the first CLK_DIV/2 cycles of a bit and 1 for the second half.
    - After WIDTH bits, go to PARITY if PARITY_EN, else GAP.
  - PARITY: one bit period carrying the XOR of the payload -> GAP.
  - GAP: ser_frame_out=0, ser_clk_out=0 for CLK_DIV cycles -> IDLE.
  - Frame-high duration is exactly (WIDTH+PARITY_EN)*CLK_DIV cycles.
  - peer_ready falling mid-frame is ignored; the word completes.
  - tx_ready=0 in every state except IDLE.
- RX path:
  - On each rising edge of synced ser_clk_in while synced ser_frame_in=1, shift in the synced data bit and increment the bit counter.
  - When the counter reaches WIDTH+PARITY_EN, the word is complete and the counter clears.
    - Parity mismatch: drop the word, pulse parity_err.
    - Else, FIFO full with no pop this cycle: drop the word, pulse overflow.
    - Else: push. rx_valid/rx_count update the next cycle.
  - Falling edge of synced ser_frame_in with a partial count: discard, clear the counter, no flags.
  - Clock edges while the frame is low are ignored.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Simultaneous push and pop at full: pop then push, no overflow, count unchanged.
  - Simultaneous push and pop at empty: push only, since rx_pop is ignored.
- Latency, payload start to rx_valid=1: last rising ser_clk_in edge + 2 sync cycles + 1 edge-detect cycle + 1 push cycle.

Decomposition:
- Package serial_link_pkg:
  - TX state enum (IDLE, WAIT_PEER, SHIFT, PARITY, GAP).
  - Even-parity function.
  - Width helper based on clog2.
- Sub-module sync_fifo (WIDTH, DEPTH): push, pop, full, empty, count, head data.
- The 2-flop synchronisers are inline.

Test Plan:
- Loopback, out wired to in, WIDTH=8, CLK_DIV=4, peer_ready tied 1; send 0xA5 -> frame high 32 cycles, data MSB-first 1,0,1,0,0,1,0,1; rx_data=0xA5, rx_count=1, no flags.
- peer_ready_in=0, send 0x3C -> tx_ready=0, ser_frame_out stays 0; raise peer_ready -> frame starts 3 cycles later (2 sync + entry); loopback delivers 0x3C.
- DEPTH=4, no pops, send 0x01..0x05 -> rx_count=4, local_ready_out=0 after 4th word, overflow pulses once on 5th; pop order 0x01,0x02,0x03,0x04.
- PARITY_EN=1, drive RX by bench with 0x0F and parity bit 1 -> parity_err pulses, rx_count unchanged; correct parity 0 -> word pushed.
- Bench drops ser_frame_in after 5 of 8 bits, then sends a full 0x81 -> only 0x81 enters the FIFO, no flags.
- Assert rst in the middle of a SHIFT of 0xFF -> all outputs at reset values immediately; next word 0x12 after release is transmitted and received correctly.
